// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that time-shares a single DATAWIDTH adder among NUM_REQ
// requesters, returning a registered sum with a one-cycle done pulse.
module add_share_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 4
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   a_in,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   b_in,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATAWIDTH-1:0]           sum_out,
  output logic                           busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [DATAWIDTH-1:0] sum_q;
  logic [DATAWIDTH-1:0] op_a_q;
  logic [DATAWIDTH-1:0] op_b_q;
  logic [PTR_W-1:0]     ptr_q;

  logic [DATAWIDTH-1:0] a_slice [NUM_REQ];
  logic [DATAWIDTH-1:0] b_slice [NUM_REQ];
  logic [NUM_REQ-1:0]   arb_vec;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     ptr_d;
  logic                 win_found;
  logic [DATAWIDTH-1:0] add_sum;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign a_slice[g] = a_in[g*DATAWIDTH +: DATAWIDTH];
    assign b_slice[g] = b_in[g*DATAWIDTH +: DATAWIDTH];
  end

  // The shared ADD: fed only from the operand registers, carry discarded.
  assign add_sum = op_a_q + op_b_q;

  // The requester just served is masked so it cannot win twice in a row.
  assign arb_vec = (state_q == DONE) ? (req & ~gnt_q) : req;

  // NOTE: every variable written in always_comb gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    logic [PTR_W-1:0] idx;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && arb_vec[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    win_onehot[win_idx] = 1'b1;
    ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      sum_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_q   <= win_onehot;
            op_a_q  <= a_slice[win_idx];
            op_b_q  <= b_slice[win_idx];
            ptr_q   <= ptr_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          sum_q   <= add_sum;
          done_q  <= gnt_q;
          state_q <= DONE;
        end
        DONE: begin
          done_q <= '0;
          if (win_found) begin
            gnt_q   <= win_onehot;
            op_a_q  <= a_slice[win_idx];
            op_b_q  <= b_slice[win_idx];
            ptr_q   <= ptr_d;
            state_q <= EXEC;
          end else begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          done_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level round-robin model.
module tb_add_share_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int PW = 2;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] a_in;
  logic [NR*DW-1:0] b_in;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic [DW-1:0]    sum_out;
  logic             busy;

  logic [DW-1:0] a_op [NR];
  logic [DW-1:0] b_op [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign a_in[g*DW +: DW] = a_op[g];
    assign b_in[g*DW +: DW] = b_op[g];
  end

  add_share_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .done    (done),
    .sum_out (sum_out),
    .busy    (busy)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Transaction model: m_exec = requester whose add finishes at the next edge,
  // m_last = requester whose done pulse is showing (excluded from next pick).
  int            m_ptr;
  int            m_exec;
  int            m_last;
  int            m_res;
  logic [NR-1:0] exp_gnt;
  logic [NR-1:0] exp_done;
  logic [DW-1:0] exp_sum;
  logic          exp_busy;

  function automatic logic [NR-1:0] onehot(int w);
    return NR'(1) << w;
  endfunction

  function automatic int rr_pick(logic [NR-1:0] v, int p);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (p + k) % NR;
      if (v[PW'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_exec = -1; m_last = -1; m_res = 0;
    exp_gnt = '0; exp_done = '0; exp_sum = '0; exp_busy = 1'b0;
  endtask

  // One clock: update the model from inputs sampled at the edge, return at negedge.
  task automatic tick();
    logic [NR-1:0] mask;
    int w;
    @(posedge Clk);
    if (m_exec >= 0) begin
      exp_done = onehot(m_exec);
      exp_sum  = DW'(m_res);
      m_last   = m_exec;
      m_exec   = -1;
    end else begin
      exp_done = '0;
      mask     = (m_last >= 0) ? ~onehot(m_last) : '1;
      m_last   = -1;
      w        = rr_pick(req & mask, m_ptr);
      if (w >= 0) begin
        exp_gnt = onehot(w);
        m_exec  = w;
        m_res   = (int'(a_op[PW'(w)]) + int'(b_op[PW'(w)])) % (1 << DW);
        m_ptr   = (w + 1) % NR;
      end else begin
        exp_gnt = '0;
      end
    end
    exp_busy = (exp_gnt != '0);
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    Rst = 1'b0;
    req = '0;
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin a_op[i] = '0; b_op[i] = '0; end
    model_reset();
    #1;
    checks++; if (gnt !== '0)     begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (done !== '0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sum_out !== '0) begin errors++; $display("FAIL reset_sum: got %0d want 0", sum_out); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_basic();
    a_op[0] = 8'd10; b_op[0] = 8'd5; req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %b want 0001", gnt); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL basic_early_done: got %b want 0000", done); end
    req = '0; a_op[0] = 8'($urandom_range(0, 255)); b_op[0] = 8'($urandom_range(0, 255));
    tick();
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL basic_done: got %b want 0001", done); end
    checks++; if (sum_out !== 8'd15) begin errors++; $display("FAIL basic_sum: got %0d want 15", sum_out); end
    tick();
    checks++; if ({done, gnt, busy} !== 9'b0) begin
      errors++; $display("FAIL basic_idle: got done=%b gnt=%b busy=%b want all 0", done, gnt, busy);
    end
    checks++; if (sum_out !== 8'd15) begin errors++; $display("FAIL basic_sum_hold: got %0d want 15", sum_out); end
  endtask

  task automatic test_overflow();
    a_op[2] = 8'd200; b_op[2] = 8'd100; req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ovf_gnt: got %b want 0100", gnt); end
    req = '0;
    tick();
    checks++; if (done !== 4'b0100 || sum_out !== 8'd44) begin
      errors++; $display("FAIL ovf_done: got done=%b sum=%0d want 0100/44", done, sum_out);
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < NR; i++) begin a_op[i] = DW'(i + 1); b_op[i] = 8'd10; end
    req = 4'b1111;
    for (int c = 0; c < 2 * NR; c++) begin
      tick();
      checks++; if (gnt !== onehot(c / 2) || busy !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got gnt=%b busy=%b want %b/1", c, gnt, busy, onehot(c / 2));
      end
      if (c % 2 == 1) begin
        checks++; if (done !== onehot(c / 2) || sum_out !== DW'(11 + c / 2)) begin
          errors++; $display("FAIL b2b_done[%0d]: got done=%b sum=%0d want %b/%0d",
                             c, done, sum_out, onehot(c / 2), 11 + c / 2);
        end
        req = req & ~onehot(c / 2);
      end else begin
        checks++; if (done !== '0) begin errors++; $display("FAIL b2b_nodone[%0d]: got %b want 0", c, done); end
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || gnt !== '0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b gnt=%b want 0/0", busy, gnt);
    end
  endtask

  task automatic test_fairness();
    int order[$];
    bit reassert;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      a_op[i] = 8'($urandom_range(0, 255)); b_op[i] = 8'($urandom_range(0, 255));
    end
    req = 4'b0101;
    reassert = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if ({gnt, done, sum_out, busy} !== {exp_gnt, exp_done, exp_sum, exp_busy}) begin
        errors++; $display("FAIL fair_cycle[%0d]: got gnt=%b done=%b sum=%0d busy=%b want %b/%b/%0d/%b",
                           c, gnt, done, sum_out, busy, exp_gnt, exp_done, exp_sum, exp_busy);
      end
      for (int j = 0; j < NR; j++) if (done === onehot(j)) order.push_back(j);
      if (reassert) begin req[0] = 1'b1; reassert = 1'b0; end
      if (exp_done[0]) begin req[0] = 1'b0; reassert = 1'b1; end
    end
    req = '0;
    checks++; if (order.size() != 6) begin
      errors++; $display("FAIL fair_count: got %0d completions want 6", order.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (order[k] != ((k % 2 == 0) ? 0 : 2)) begin
          errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, order[k], (k % 2 == 0) ? 0 : 2);
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_withdrawal();
    a_op[0] = 8'($urandom_range(0, 255)); b_op[0] = 8'($urandom_range(0, 255));
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wd_gnt0: got %b want 0001", gnt); end
    req = 4'b0011;
    tick();
    checks++; if (done !== 4'b0001 || gnt[1] !== 1'b0) begin
      errors++; $display("FAIL wd_done0: got done=%b gnt=%b want 0001/0001", done, gnt);
    end
    checks++; if (sum_out !== exp_sum) begin
      errors++; $display("FAIL wd_sum: got %0d want %0d", sum_out, exp_sum);
    end
    req = 4'b0000;
    tick();
    checks++; if (busy !== 1'b0 || gnt !== '0 || done !== '0) begin
      errors++; $display("FAIL wd_idle: got busy=%b gnt=%b done=%b want 0/0/0", busy, gnt, done);
    end
    tick();
    checks++; if (gnt !== '0 || done !== '0) begin
      errors++; $display("FAIL wd_never: got gnt=%b done=%b want 0/0", gnt, done);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    a_op[2] = 8'($urandom_range(0, 255)); b_op[2] = 8'($urandom_range(0, 255));
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ares_pre_gnt: got %b want 0100", gnt); end
    #2 Rst = 1'b0;
    #1;
    checks++; if ({gnt, done, busy} !== 9'b0 || sum_out !== '0) begin
      errors++; $display("FAIL ares_clear: got gnt=%b done=%b busy=%b sum=%0d want 0", gnt, done, busy, sum_out);
    end
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    a_op[1] = 8'($urandom_range(0, 255)); b_op[1] = 8'($urandom_range(0, 255));
    a_op[3] = 8'($urandom_range(0, 255)); b_op[3] = 8'($urandom_range(0, 255));
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010 || done !== '0) begin
      errors++; $display("FAIL ares_regrant: got gnt=%b done=%b want 0010/0000", gnt, done);
    end
    req = 4'b1000;
    tick();
    checks++; if (done !== 4'b0010 || sum_out !== DW'(int'(a_op[1]) + int'(b_op[1]))) begin
      errors++; $display("FAIL ares_done: got done=%b sum=%0d want 0010/%0d", done, sum_out,
                         (int'(a_op[1]) + int'(b_op[1])) % 256);
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (exp_done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            a_op[i] = 8'($urandom_range(0, 255)); b_op[i] = 8'($urandom_range(0, 255));
          end
        end else if (exp_gnt[i]) begin
          a_op[i] = 8'($urandom_range(0, 255)); b_op[i] = 8'($urandom_range(0, 255));
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
      checks++; if ({gnt, done, sum_out, busy} !== {exp_gnt, exp_done, exp_sum, exp_busy}) begin
        errors++; $display("FAIL rand_cycle[%0d]: got gnt=%b done=%b sum=%0d busy=%b want %b/%b/%0d/%b",
                           c, gnt, done, sum_out, busy, exp_gnt, exp_done, exp_sum, exp_busy);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_fairness();
    test_withdrawal();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one ADD datapath instance (parameter DATAWIDTH) among NUM_REQ requesters using round-robin arbitration.
- Each requester holds a request with its operands and receives a one-cycle done pulse alongside the registered sum.
- Sits between HLSM-generated state logic and a single shared adder, so schedules with several additions in flight can reuse one ADD.

Parameters:
- DATAWIDTH, 8, operand and sum width; passed through to the internal ADD instance.
- NUM_REQ, 4, number of requesters; must be >= 2. The pointer is $clog2(NUM_REQ) bits wide.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request, level.
- a_in  input  NUM_REQ*DATAWIDTH  operand a. Requester i uses slice [i*DATAWIDTH +: DATAWIDTH].
- b_in  input  NUM_REQ*DATAWIDTH  operand b, sliced the same way as a_in.
- gnt  output  NUM_REQ  one-hot grant, registered.
- done  output  NUM_REQ  one-hot, one-cycle result-valid pulse, registered.
- sum_out  output  DATAWIDTH  registered sum of the last completed operation.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, gnt=0, done=0, sum_out=0, busy=0, round-robin pointer ptr=0, operand registers=0.
- FSM states: IDLE, EXEC, DONE.
- Arbitration: scan req starting at index ptr, ascending, wrapping modulo NUM_REQ. The first set bit wins. On each grant, ptr <= winner+1 (mod NUM_REQ).
- IDLE: if req != 0 at the clock edge:
  - gnt <= onehot(winner);
  - latch the winner's a_in/b_in slices into operand registers;
  - state <= EXEC.
  Otherwise remain in IDLE.
- EXEC: the ADD instance is fed only from the operand registers. At the edge: sum_out <= ADD sum; done <= gnt; state <= DONE. gnt is held.
- DONE: done and gnt are high for exactly this cycle, and sum_out is valid. At the edge, done <= 0 and the FSM re-arbitrates on masked = req & ~gnt:
  - masked != 0: grant the new winner, latch its operands, state <= EXEC. There is no IDLE bubble.
  - masked == 0: gnt <= 0, state <= IDLE.
- Latency: req sampled at edge E0 -> gnt visible after E0 -> done and sum_out visible after E1.
- Throughput: one operation per 2 cycles under back-to-back load.
- Arithmetic: sum = (a+b) mod 2^DATAWIDTH. The carry is discarded, matching ADD.
- sum_out holds its value until the next completion. It does not return to 0 after done.
- Requester contract:
  - Hold req and operands until gnt is seen.
  - Operands may change after the grant edge, since they are already latched.
  - Deassert req during or after the done cycle. Because of the DONE mask, a req still high in the done cycle is not re-granted at that edge.
- Withdrawal: req dropped before being sampled as winner is never granted and produces no done.
- Changing req or a_in/b_in during EXEC/DONE has no effect on the current operation.
- Reset mid-operation: all outputs clear immediately, no done pulse is produced for the aborted operation, and ptr returns to 0.
- busy = (state != IDLE). It is derived from the state register with no combinational path from req.

Test Plan (DATAWIDTH=8, NUM_REQ=4):
- Reset then req=0001, a0=10, b0=5.
  - Before first edge: all outputs 0.
  - After E0: gnt=0001, busy=1.
  - After E1: done=0001, sum_out=15.
  - After E2: done=0, gnt=0, busy=0; sum_out still 15.
- Overflow: req=0100, a2=200, b2=100 -> done=0100, sum_out=44.
- req=1111 from ptr=0, each requester holding a_i=i+1, b_i=10, each dropping req on its done cycle.
  - Grants 0,1,2,3 back to back, done pulses every 2 cycles.
  - Sums 11,12,13,14; busy never drops between grants.
- Fairness: req0 reasserted one cycle after every done, req2 held high -> grant order 0,2,0,2; no requester is granted twice in a row while another is pending.
- Withdrawal: while requester 0 is in EXEC, pulse req1 for one cycle then drop it -> gnt[1] and done[1] never assert; FSM returns to IDLE after done[0].
- Async reset: assert Rst=0 mid-EXEC between clock edges -> gnt, busy and done go to 0 immediately with no done pulse. After release with req=0010, the grant goes to 1 (pointer reset to 0).
